// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and defaults for the 1:2 stream demux
// Purpose: per-channel queue state encoding and default widths, imported by
//          fifo2 and demux1_2_stream.
// Contents: q_state_e (EMPTY/ONE/TWO), DEFAULT_WIDTH, DEFAULT_CNT_W.
package demux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } q_state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/demux1_2_stream_fifo2.sv
// rtl/demux1_2_stream_fifo2.sv - 2-entry FIFO queue used once per demux channel
// Purpose: holds up to two words in arrival order; slot0 is always the head.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, din_i   write din_i at the edge (ignored while full)
//   pop_i           remove head at the edge (ignored while empty)
//   head_o          head word while valid, 0 otherwise
//   valid_o         queue holds at least one word
//   full_o          queue holds two words
module fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o
);

  q_state_e         state_q, state_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (state_q != TWO);
  assign do_pop  = pop_i && (state_q != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      EMPTY: begin
        if (do_push) begin
          slot0_d = din_i;
          state_d = ONE;
        end
      end
      ONE: begin
        // Simultaneous push and pop replaces the head and keeps one word.
        if (do_push && do_pop) begin
          slot0_d = din_i;
        end else if (do_push) begin
          slot1_d = din_i;
          state_d = TWO;
        end else if (do_pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (do_pop) begin
          slot0_d = slot1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid_o = (state_q != EMPTY);
  assign full_o  = (state_q == TWO);
  assign head_o  = valid_o ? slot0_q : '0;

endmodule

// File: rtl/demux1_2_stream.sv
// rtl/demux1_2_stream.sv - buffered 1-to-2 valid/ready stream demultiplexer
// Purpose: steers each input word by S into one of two independent 2-entry
//          queues; each output drains at its own pace.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   In, InValid, S, InReady    input stream and route select (0=A, 1=B)
//   OutA, OutAValid, OutAReady channel A output stream
//   OutB, OutBValid, OutBReady channel B output stream
//   CountA, CountB             wrapping counts of output handshakes
// Build option: DEMUX_COUNT_EN enables the counters; otherwise they read 0.
module demux1_2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             InValid,
  input  logic             S,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic             OutAValid,
  input  logic             OutAReady,
  output logic [WIDTH-1:0] OutB,
  output logic             OutBValid,
  input  logic             OutBReady,
  output logic [CNT_W-1:0] CountA,
  output logic [CNT_W-1:0] CountB
);

  logic full_a, full_b;
  logic push_a, push_b;
  logic pop_a, pop_b;

  // Ready depends only on S and registered fullness, never on consumer ready.
  assign InReady = S ? !full_b : !full_a;
  assign push_a  = InValid && InReady && !S;
  assign push_b  = InValid && InReady && S;
  assign pop_a   = OutAValid && OutAReady;
  assign pop_b   = OutBValid && OutBReady;

  fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a),
    .pop_i   (OutAReady),
    .din_i   (In),
    .head_o  (OutA),
    .valid_o (OutAValid),
    .full_o  (full_a)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b),
    .pop_i   (OutBReady),
    .din_i   (In),
    .head_o  (OutB),
    .valid_o (OutBValid),
    .full_o  (full_b)
  );

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] count_a_q, count_a_d;
  logic [CNT_W-1:0] count_b_q, count_b_d;

  always_comb begin
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    if (pop_a) count_a_d = count_a_q + CNT_W'(1);
    if (pop_b) count_b_d = count_b_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_a_q <= '0;
      count_b_q <= '0;
    end else begin
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
    end
  end

  assign CountA = count_a_q;
  assign CountB = count_b_q;
`else
  logic unused_pops;
  assign unused_pops = pop_a ^ pop_b;
  assign CountA = '0;
  assign CountB = '0;
`endif

endmodule

// File: tb/tb_demux1_2_stream.sv
// tb/tb_demux1_2_stream.sv - self-checking bench for demux1_2_stream
module tb_demux1_2_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_w = '0;
  logic        in_valid = 1'b0;
  logic        s = 1'b0;
  logic        in_ready;
  logic [15:0] out_a, out_b;
  logic        out_a_valid, out_b_valid;
  logic        out_a_ready = 1'b0;
  logic        out_b_ready = 1'b0;
  logic [7:0]  count_a, count_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two plain queues plus pop counters.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          cnt_a = 0;
  int          cnt_b = 0;

  demux1_2_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (in_w),
    .InValid   (in_valid),
    .S         (s),
    .InReady   (in_ready),
    .OutA      (out_a),
    .OutAValid (out_a_valid),
    .OutAReady (out_a_ready),
    .OutB      (out_b),
    .OutBValid (out_b_valid),
    .OutBReady (out_b_ready),
    .CountA    (count_a),
    .CountB    (count_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int c);
`ifdef DEMUX_COUNT_EN
    return 32'(c % 256);
`else
    return 32'(c - c);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      bit pa, pb, wa, wb;
      pa = (qa.size() > 0) && out_a_ready;
      pb = (qb.size() > 0) && out_b_ready;
      wa = in_valid && !s && (qa.size() < 2);
      wb = in_valid && s && (qb.size() < 2);
      if (pa) begin void'(qa.pop_front()); cnt_a++; end
      if (pb) begin void'(qb.pop_front()); cnt_b++; end
      if (wa) qa.push_back(in_w);
      if (wb) qb.push_back(in_w);
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(s ? (qb.size() < 2) : (qa.size() < 2)));
    check("a_valid", 32'(out_a_valid), 32'(qa.size() > 0));
    check("a_data", 32'(out_a), (qa.size() > 0) ? 32'(qa[0]) : 32'h0);
    check("b_valid", 32'(out_b_valid), 32'(qb.size() > 0));
    check("b_data", 32'(out_b), (qb.size() > 0) ? 32'(qb[0]) : 32'h0);
    check("count_a", 32'(count_a), exp_cnt(cnt_a));
    check("count_b", 32'(count_b), exp_cnt(cnt_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    s = 1'b0;
    in_w = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_a_valid", 32'(out_a_valid), 32'h0);
    check("rst_b_valid", 32'(out_b_valid), 32'h0);
    check("rst_a_data", 32'(out_a), 32'h0);
    check("rst_b_data", 32'(out_b), 32'h0);
    check("rst_count_a", 32'(count_a), 32'h0);
    check("rst_count_b", 32'(count_b), 32'h0);
    step();

    // Single route to A.
    in_w = 16'h1234; s = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_a_data", 32'(out_a), 32'h1234);
    check("single_a_valid", 32'(out_a_valid), 32'h1);
    check("single_b_valid", 32'(out_b_valid), 32'h0);
    step();

    // Fill and block.
    do_reset();
    in_valid = 1'b1; s = 1'b0; in_w = 16'h0001;
    step();
    in_w = 16'h0002;
    step();
    in_w = 16'h0003;
    @(negedge clk);
    check("full_ready_s0", 32'(in_ready), 32'h0);
    #1 s = 1'b1;
    #1 check("full_ready_s1", 32'(in_ready), 32'h1);
    in_valid = 1'b0; s = 1'b0;
    step();
    out_a_ready = 1'b1;
    @(negedge clk);
    check("drain_first", 32'(out_a), 32'h0001);
    step();
    @(negedge clk);
    check("drain_second", 32'(out_a), 32'h0002);
    step();
    out_a_ready = 1'b0;
    @(negedge clk);
    check("drain_count_a", 32'(count_a), exp_cnt(2));
    check("drain_empty", 32'(out_a_valid), 32'h0);
    step();

    // Streaming on B.
    do_reset();
    out_b_ready = 1'b1; s = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_w = 16'h0010 + 16'(i);
      @(negedge clk);
      check("stream_ready", 32'(in_ready), 32'h1);
      if (i > 0) check("stream_data", 32'(out_b), 32'h0010 + 32'(i) - 32'h1);
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("stream_count_b", 32'(count_b), exp_cnt(16));
    check("stream_b_empty", 32'(out_b_valid), 32'h0);
    step();

    // Simultaneous push/pop on A while B pops.
    do_reset();
    in_valid = 1'b1; s = 1'b0; in_w = 16'h00A1;
    step();
    s = 1'b1; in_w = 16'h00B1;
    step();
    s = 1'b0; in_w = 16'h00A2; out_a_ready = 1'b1; out_b_ready = 1'b1;
    step();
    idle_inputs();
    @(negedge clk);
    check("simul_a_head", 32'(out_a), 32'h00A2);
    check("simul_a_valid", 32'(out_a_valid), 32'h1);
    check("simul_b_valid", 32'(out_b_valid), 32'h0);
    step();

    // 256 pops on A wrap the counter.
    do_reset();
    out_a_ready = 1'b1; s = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_w = 16'(i * 7 + 3);
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("wrap_count_a", 32'(count_a), 32'h0);
    step();

    // Reset with both queues full.
    idle_inputs();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = i[1];
      in_w = 16'hC000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_a_full", 32'(out_a), 32'hC000);
    check("pre_rst_b_full", 32'(out_b), 32'hC002);
    #2 rst_n = 1'b0;
    #1;
    check("async_a_valid", 32'(out_a_valid), 32'h0);
    check("async_b_valid", 32'(out_b_valid), 32'h0);
    check("async_a_data", 32'(out_a), 32'h0);
    check("async_count_b", 32'(count_b), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'h1);
    check("post_rst_b_valid", 32'(out_b_valid), 32'h0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid    = 1'($urandom_range(0, 3) != 0);
      s           = 1'($urandom);
      in_w        = 16'($urandom);
      out_a_ready = 1'($urandom_range(0, 2) != 0);
      out_b_ready = 1'($urandom_range(0, 3) == 0);
      step();
    end
    idle_inputs();
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
